// File: rtl/fetch_queue.sv
// Instruction fetch queue: 8-byte bundles from the I-cache in, up to two instructions per cycle out to decode.
// Latency: one edge from enqueue to the outputs; outputs are combinational reads at head/head+1.
// Backpressure: in_ready drops when fewer than two free entries remain; flush empties the queue at the edge.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PW    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_pc,
    input  logic [63:0]             in_data,
    input  logic [2*PW-1:0]         in_pdc,
    output logic [1:0]              out_valid,
    output logic [31:0]             out_pc0,
    output logic [31:0]             out_pc1,
    output logic [31:0]             out_ins0,
    output logic [31:0]             out_ins1,
    output logic [PW-1:0]           out_pdc0,
    output logic [PW-1:0]           out_pdc1,
    input  logic [1:0]              deq_cnt,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   ins;
        logic [PW-1:0] pdc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] tail_p1;
    logic [AW-1:0] head_p1;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    n_avail;
    logic [1:0]    n_deq;
    logic [1:0]    n_enq;
    logic          enq_fire;
    entry_t        rd0;
    entry_t        rd1;

    // Ready looks only at registered occupancy so it never depends on this cycle's dequeue.
    assign in_ready = (CW'(DEPTH) - count_q) >= CW'(2);

    always_comb begin
        n_avail  = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
        n_deq    = (deq_cnt > n_avail) ? n_avail : deq_cnt;
        n_enq    = in_pc[2] ? 2'd1 : 2'd2;
        enq_fire = in_valid && in_ready;
        tail_p1  = tail_q + AW'(1);
        head_p1  = head_q + AW'(1);
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q + AW'(n_deq);
        tail_d  = tail_q;
        count_d = count_q - CW'(n_deq);
        if (enq_fire) begin
            tail_d  = tail_q + AW'(n_enq);
            count_d = count_d + CW'(n_enq);
            // An odd-word PC means word0 precedes the fetch target and is dropped.
            if (in_pc[2]) begin
                mem_d[tail_q] = '{pc: in_pc, ins: in_data[63:32], pdc: in_pdc[2*PW-1:PW]};
            end else begin
                mem_d[tail_q]  = '{pc: in_pc, ins: in_data[31:0], pdc: in_pdc[PW-1:0]};
                mem_d[tail_p1] = '{pc: in_pc + 32'd4, ins: in_data[63:32], pdc: in_pdc[2*PW-1:PW]};
            end
        end
        if (flush) begin
            mem_d   = mem_q;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        rd0       = mem_q[head_q];
        rd1       = mem_q[head_p1];
        out_valid = (count_q >= CW'(2)) ? 2'b11 : (count_q == CW'(1)) ? 2'b01 : 2'b00;
        out_pc0   = rd0.pc;
        out_ins0  = rd0.ins;
        out_pdc0  = rd0.pdc;
        out_pc1   = rd1.pc;
        out_ins1  = rd1.ins;
        out_pdc1  = rd1.pdc;
        count     = count_q;
    end

endmodule
